// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants, types and helpers for the register file and its
// write-pending scoreboard.
package regfile_scoreboard_pkg;

  localparam int REG_NUM     = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;

  typedef logic [RADDR_WIDTH-1:0] raddr_t;
  typedef logic [RDATA_WIDTH-1:0] rdata_t;
  typedef logic [RADDR_WIDTH:0]   cnt_t;

  localparam raddr_t ZERO_REG = 5'd0;
  localparam rdata_t ZERO     = 32'd0;

  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam cnt_t CNT_ZERO = 6'd0;
  localparam cnt_t CNT_ONE  = 6'd1;
  localparam cnt_t CNT_MAX  = 6'd31;

  // Direction the pending counter moves on the coming edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // x0 is hardwired zero, so only nonzero addresses name real state.
  function automatic logic addr_valid(input raddr_t addr);
    return addr != ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back side bundle for the register file. The master is the
// pipeline (decode + WB), the slave is the register file itself.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  raddr_t reg1_raddr_i;
  logic   reg1_re_i;
  raddr_t reg2_raddr_i;
  logic   reg2_re_i;
  rdata_t reg1_rdata_o;
  rdata_t reg2_rdata_o;
  logic   reg_we_i;
  raddr_t reg_waddr_i;
  rdata_t reg_wdata_i;
  logic   issue_valid_i;
  logic   issue_we_i;
  raddr_t issue_waddr_i;
  logic   hazard_o;
  cnt_t   pending_cnt_o;

  modport master (
    output reg1_raddr_i, reg1_re_i, reg2_raddr_i, reg2_re_i,
    output reg_we_i, reg_waddr_i, reg_wdata_i,
    output issue_valid_i, issue_we_i, issue_waddr_i,
    input  reg1_rdata_o, reg2_rdata_o, hazard_o, pending_cnt_o
  );

  modport slave (
    input  reg1_raddr_i, reg1_re_i, reg2_raddr_i, reg2_re_i,
    input  reg_we_i, reg_waddr_i, reg_wdata_i,
    input  issue_valid_i, issue_we_i, issue_waddr_i,
    output reg1_rdata_o, reg2_rdata_o, hazard_o, pending_cnt_o
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one pending bit per architectural register,
// set by an issuing producer, cleared by its write-back. Set beats clear
// on the same address. Also keeps a running population count and raises
// the read hazard used by decode to stall.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  raddr_t rd1_addr,
  input  logic   rd1_en,
  input  logic   rd1_bypass,
  input  raddr_t rd2_addr,
  input  logic   rd2_en,
  input  logic   rd2_bypass,
  input  logic   wb_en,
  input  raddr_t wb_addr,
  input  logic   issue_valid,
  input  logic   issue_we,
  input  raddr_t issue_addr,
  output logic   hazard,
  output cnt_t   pending_cnt
);

  logic [REG_NUM-1:1] pending_r;
  logic [REG_NUM-1:1] pending_clr_s;
  logic [REG_NUM-1:1] pending_nxt_s;
  logic    haz1_s;
  logic    haz2_s;
  logic    set_fire_s;
  logic    clr_fire_s;
  logic    inc_s;
  logic    dec_s;
  cnt_op_e cnt_op_s;
  cnt_t    cnt_r;

  // Per-port hazard: enabled read of a pending, non-bypassed register.
  always_comb begin
    haz1_s = 1'b0;
    haz2_s = 1'b0;
    if (rd1_en == READ_ENABLE && addr_valid(rd1_addr)) begin
      haz1_s = pending_r[rd1_addr] & ~rd1_bypass;
    end else begin
      haz1_s = 1'b0;
    end
    if (rd2_en == READ_ENABLE && addr_valid(rd2_addr)) begin
      haz2_s = pending_r[rd2_addr] & ~rd2_bypass;
    end else begin
      haz2_s = 1'b0;
    end
  end

  assign hazard      = haz1_s | haz2_s;
  // A stalled decode must not mark its destination pending.
  assign set_fire_s  = issue_valid & issue_we & addr_valid(issue_addr) & ~hazard;
  assign clr_fire_s  = (wb_en == WRITE_ENABLE) & addr_valid(wb_addr);
  assign pending_cnt = cnt_r;

  // Apply the write-back clear first.
  always_comb begin
    pending_clr_s = pending_r;
    if (clr_fire_s) begin
      pending_clr_s[wb_addr] = 1'b0;
    end else begin
      pending_clr_s = pending_r;
    end
  end

  // Apply the issue set on top of the clear so the new producer wins.
  always_comb begin
    pending_nxt_s = pending_clr_s;
    if (set_fire_s) begin
      pending_nxt_s[issue_addr] = 1'b1;
    end else begin
      pending_nxt_s = pending_clr_s;
    end
  end

  // Counter moves only when a bit actually flips; opposite flips cancel.
  always_comb begin
    inc_s    = 1'b0;
    dec_s    = 1'b0;
    cnt_op_s = CNT_HOLD;
    if (set_fire_s) begin
      inc_s = ~pending_r[issue_addr];
    end else begin
      inc_s = 1'b0;
    end
    if (clr_fire_s) begin
      dec_s = pending_r[wb_addr] & ~(set_fire_s && (issue_addr == wb_addr));
    end else begin
      dec_s = 1'b0;
    end
    case ({inc_s, dec_s})
      2'b10:   cnt_op_s = CNT_INC;
      2'b01:   cnt_op_s = CNT_DEC;
      default: cnt_op_s = CNT_HOLD;
    endcase
  end

  // Pending bit vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {(REG_NUM-1){1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Saturating population counter tracking the pending vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      case (cnt_op_s)
        CNT_INC: begin
          if (cnt_r < CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
          else                 cnt_r <= cnt_r;
        end
        CNT_DEC: begin
          if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CNT_ONE;
          else                   cnt_r <= cnt_r;
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_scoreboard_top.sv
// Integer register file with two combinational read ports, one write-back
// port and a write-pending scoreboard for decode stalls.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write-back data to
// the read ports and suppresses the hazard for those reads.
module regfile_scoreboard_top
  import regfile_scoreboard_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  rdata_t regs_r [1:REG_NUM-1];
  rdata_t rd1_s;
  rdata_t rd2_s;
  logic   wr_fire_s;
  logic   hit1_s;
  logic   hit2_s;

  assign wr_fire_s = (bus.reg_we_i == WRITE_ENABLE) & addr_valid(bus.reg_waddr_i);

`ifdef REGFILE_BYPASS_EN
  assign hit1_s = wr_fire_s & (bus.reg_waddr_i == bus.reg1_raddr_i);
  assign hit2_s = wr_fire_s & (bus.reg_waddr_i == bus.reg2_raddr_i);
`else
  assign hit1_s = 1'b0;
  assign hit2_s = 1'b0;
`endif

  // Storage array; x0 is not stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < REG_NUM; i++) regs_r[i] <= ZERO;
    end else if (wr_fire_s) begin
      regs_r[bus.reg_waddr_i] <= bus.reg_wdata_i;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Read muxes: disabled, reset or x0 read zero; bypass beats storage.
  always_comb begin
    rd1_s = ZERO;
    rd2_s = ZERO;
    if (rst || bus.reg1_re_i != READ_ENABLE || !addr_valid(bus.reg1_raddr_i)) begin
      rd1_s = ZERO;
    end else if (hit1_s) begin
      rd1_s = bus.reg_wdata_i;
    end else begin
      rd1_s = regs_r[bus.reg1_raddr_i];
    end
    if (rst || bus.reg2_re_i != READ_ENABLE || !addr_valid(bus.reg2_raddr_i)) begin
      rd2_s = ZERO;
    end else if (hit2_s) begin
      rd2_s = bus.reg_wdata_i;
    end else begin
      rd2_s = regs_r[bus.reg2_raddr_i];
    end
  end

  assign bus.reg1_rdata_o = rd1_s;
  assign bus.reg2_rdata_o = rd2_s;

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rd1_addr    (bus.reg1_raddr_i),
    .rd1_en      (bus.reg1_re_i),
    .rd1_bypass  (hit1_s),
    .rd2_addr    (bus.reg2_raddr_i),
    .rd2_en      (bus.reg2_re_i),
    .rd2_bypass  (hit2_s),
    .wb_en       (bus.reg_we_i),
    .wb_addr     (bus.reg_waddr_i),
    .issue_valid (bus.issue_valid_i),
    .issue_we    (bus.issue_we_i),
    .issue_addr  (bus.issue_waddr_i),
    .hazard      (bus.hazard_o),
    .pending_cnt (bus.pending_cnt_o)
  );

endmodule

// File: tb/tb_regfile_scoreboard_top.sv
// Bench for regfile_scoreboard_top: expectations are queued as stimulus is
// driven and compared against the outputs once they have settled.
module tb_regfile_scoreboard_top;
  import regfile_scoreboard_pkg::*;

  localparam int K_RD1 = 0;
  localparam int K_RD2 = 1;
  localparam int K_HAZ = 2;
  localparam int K_CNT = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  regfile_scoreboard_if bus();

  regfile_scoreboard_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t        exp_q[$];
  logic [31:0] mem [0:31];
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog against a runaway run.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_RD1:   obs = bus.reg1_rdata_o;
        K_RD2:   obs = bus.reg2_rdata_o;
        K_HAZ:   obs = {31'd0, bus.hazard_o};
        default: obs = {26'd0, bus.pending_cnt_o};
      endcase
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic sample();
    #2;
    drain();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg1_re_i     = READ_DISABLE;
    bus.reg2_re_i     = READ_DISABLE;
    bus.reg1_raddr_i  = 5'd0;
    bus.reg2_raddr_i  = 5'd0;
    bus.reg_we_i      = WRITE_DISABLE;
    bus.reg_waddr_i   = 5'd0;
    bus.reg_wdata_i   = 32'd0;
    bus.issue_valid_i = 1'b0;
    bus.issue_we_i    = 1'b0;
    bus.issue_waddr_i = 5'd0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.reg_we_i    = WRITE_ENABLE;
    bus.reg_waddr_i = a;
    bus.reg_wdata_i = d;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.issue_valid_i = 1'b1;
    bus.issue_we_i    = 1'b1;
    bus.issue_waddr_i = a;
  endtask

  initial begin
    logic [4:0]  wa;
    logic [4:0]  prev;
    logic [31:0] wd;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    rst = 1'b1;
    idle();

    // Reset state with reads enabled on x5
    bus.reg1_re_i = READ_ENABLE; bus.reg1_raddr_i = 5'd5;
    bus.reg2_re_i = READ_ENABLE; bus.reg2_raddr_i = 5'd5;
    expect_val("rst_rd1", K_RD1, 32'd0);
    expect_val("rst_rd2", K_RD2, 32'd0);
    expect_val("rst_haz", K_HAZ, 32'd0);
    expect_val("rst_cnt", K_CNT, 32'd0);
    sample();
    step();
    rst = 1'b0;
    idle();

    // x0 write is discarded
    step(); wb(5'd0, 32'hDEADBEEF);
    step(); idle();
    bus.reg1_re_i = READ_ENABLE; bus.reg1_raddr_i = 5'd0;
    expect_val("x0_rd", K_RD1, 32'd0);
    expect_val("x0_cnt", K_CNT, 32'd0);
    sample();

    // Basic write and read of x3, including same-cycle read
    step(); idle(); wb(5'd3, 32'h12345678);
    bus.reg2_re_i = READ_ENABLE; bus.reg2_raddr_i = 5'd3;
`ifdef REGFILE_BYPASS_EN
    expect_val("x3_samecyc", K_RD2, 32'h12345678);
`else
    expect_val("x3_samecyc", K_RD2, 32'd0);
`endif
    sample();
    mem[3] = 32'h12345678;
    step(); idle();
    bus.reg2_re_i = READ_ENABLE; bus.reg2_raddr_i = 5'd3;
    bus.reg1_re_i = READ_ENABLE; bus.reg1_raddr_i = 5'd3;
    expect_val("x3_rd2", K_RD2, 32'h12345678);
    expect_val("x3_rd1", K_RD1, 32'h12345678);
    sample();
    bus.reg2_re_i = READ_DISABLE;
    expect_val("x3_re0", K_RD2, 32'd0);
    sample();

    // Random write/read-back patterns against the model
    prev = 5'd3;
    for (int i = 0; i < 8; i++) begin
      wa = 5'($urandom_range(31, 1));
      wd = $urandom;
      step(); idle(); wb(wa, wd);
      step(); idle();
      mem[wa] = wd;
      bus.reg1_re_i = READ_ENABLE; bus.reg1_raddr_i = wa;
      bus.reg2_re_i = READ_ENABLE; bus.reg2_raddr_i = prev;
      expect_val("rnd_rd1", K_RD1, mem[wa]);
      expect_val("rnd_rd2", K_RD2, mem[prev]);
      expect_val("rnd_haz", K_HAZ, 32'd0);
      sample();
      prev = wa;
    end

    // RAW stall on x7; an issue during the stall must not take effect
    step(); idle(); issue(5'd7);
    expect_val("raw_issue_haz", K_HAZ, 32'd0);
    sample();
    step(); idle(); issue(5'd10);
    bus.reg1_re_i = READ_ENABLE; bus.reg1_raddr_i = 5'd7;
    expect_val("raw_cnt1", K_CNT, 32'd1);
    expect_val("raw_haz", K_HAZ, 32'd1);
    expect_val("raw_old", K_RD1, mem[7]);
    sample();
    step(); idle(); wb(5'd7, 32'h000000A5);
    bus.reg1_re_i = READ_ENABLE; bus.reg1_raddr_i = 5'd7;
    expect_val("raw_suppress_cnt", K_CNT, 32'd1);
`ifdef REGFILE_BYPASS_EN
    expect_val("raw_wb_haz", K_HAZ, 32'd0);
    expect_val("raw_wb_rd", K_RD1, 32'h000000A5);
`else
    expect_val("raw_wb_haz", K_HAZ, 32'd1);
    expect_val("raw_wb_rd", K_RD1, mem[7]);
`endif
    sample();
    mem[7] = 32'h000000A5;
    step(); idle();
    bus.reg1_re_i = READ_ENABLE; bus.reg1_raddr_i = 5'd7;
    expect_val("raw_after_haz", K_HAZ, 32'd0);
    expect_val("raw_after_rd", K_RD1, 32'h000000A5);
    expect_val("raw_after_cnt", K_CNT, 32'd0);
    sample();

    // Set/clear collision on x9
    step(); idle(); issue(5'd9);
    step(); idle();
    expect_val("col_cnt_pre", K_CNT, 32'd1);
    sample();
    step(); idle(); wb(5'd9, 32'h00000099); issue(5'd9);
    step(); idle();
    mem[9] = 32'h00000099;
    bus.reg2_re_i = READ_ENABLE; bus.reg2_raddr_i = 5'd9;
    expect_val("col_cnt", K_CNT, 32'd1);
    expect_val("col_haz", K_HAZ, 32'd1);
    expect_val("col_rd", K_RD2, 32'h00000099);
    sample();
    step(); idle(); wb(5'd9, 32'h00000055);
    step(); idle();
    mem[9] = 32'h00000055;
    expect_val("col_clear_cnt", K_CNT, 32'd0);
    sample();

    // Asynchronous reset between edges with x4 and x6 pending
    step(); idle(); wb(5'd4, 32'h00000044);
    step(); idle(); wb(5'd6, 32'h00000066); issue(5'd4);
    step(); idle(); issue(5'd6);
    step(); idle();
    bus.reg1_re_i = READ_ENABLE; bus.reg1_raddr_i = 5'd4;
    bus.reg2_re_i = READ_ENABLE; bus.reg2_raddr_i = 5'd6;
    expect_val("ar_pre_cnt", K_CNT, 32'd2);
    expect_val("ar_pre_haz", K_HAZ, 32'd1);
    expect_val("ar_pre_rd1", K_RD1, 32'h00000044);
    expect_val("ar_pre_rd2", K_RD2, 32'h00000066);
    sample();
    #1 rst = 1'b1;
    #1;
    expect_val("ar_haz", K_HAZ, 32'd0);
    expect_val("ar_cnt", K_CNT, 32'd0);
    expect_val("ar_rd1", K_RD1, 32'd0);
    expect_val("ar_rd2", K_RD2, 32'd0);
    drain();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    #1 rst = 1'b0;
    step();
    expect_val("ar_post_rd1", K_RD1, 32'd0);
    expect_val("ar_post_haz", K_HAZ, 32'd0);
    expect_val("ar_post_cnt", K_CNT, 32'd0);
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard_top.md
# regfile_scoreboard_top

Integer register file and write-pending scoreboard: the responder at the far end of the decode stage's read-request interface (reg1/reg2 address plus read-enable in, read data out). It serves two combinational read ports and one write-back port. It tracks registers whose producing instruction has issued but not yet written back, and raises a hazard flag so decode can stall. It sits beside the ID stage; write-back arrives from the WB stage.

## Interface
- `REG_NUM`, 32, number of architectural registers; x0 is hardwired zero.
- `RADDR_WIDTH`, 5, register address width, log2(REG_NUM).
- `RDATA_WIDTH`, 32, register data width.
- `clk  in  1`  clock; all state updates on the rising edge.
- `rst  in  1`  reset, asynchronous, active-high.
- `reg1_raddr_i  in  RADDR_WIDTH`  read port 1 address from decode.
- `reg1_re_i  in  1`  read port 1 enable.
- `reg2_raddr_i  in  RADDR_WIDTH`  read port 2 address.
- `reg2_re_i  in  1`  read port 2 enable.
- `reg1_rdata_o  out  RDATA_WIDTH`  read port 1 data, combinational.
- `reg2_rdata_o  out  RDATA_WIDTH`  read port 2 data, combinational.
- `reg_we_i  in  1`  write-back enable from WB.
- `reg_waddr_i  in  RADDR_WIDTH`  write-back address.
- `reg_wdata_i  in  RDATA_WIDTH`  write-back data.
- `issue_valid_i  in  1`  decode issues an instruction this cycle.
- `issue_we_i  in  1`  the issued instruction writes rd.
- `issue_waddr_i  in  RADDR_WIDTH`  rd of the issued instruction.
- `hazard_o  out  1`  an enabled read targets a pending register; decode must stall.
- `pending_cnt_o  out  RADDR_WIDTH+1`  number of registers currently pending.

## Operation
- **Storage:** registers x1..x(REG_NUM-1) plus `pending[REG_NUM-1:1]`.
  - Reset clears all registers, all pending bits and `pending_cnt_o` to 0.
- **Read:**
  - If `reN` is low, `regN_rdata_o` = 0.
  - If the address is 0, `regN_rdata_o` = 0.
  - Otherwise `regN_rdata_o` = stored value, subject to bypass (see Configuration).
- **Write:** on the edge, when `reg_we_i` is high and `reg_waddr_i` != 0, store `reg_wdata_i`. Writes to x0 are discarded.
- **Scoreboard clear:** when `reg_we_i` is high and `reg_waddr_i` != 0, clear `pending[reg_waddr_i]` on the edge.
- **Scoreboard set:** when `issue_valid_i` and `issue_we_i` are high, `issue_waddr_i` != 0 and `hazard_o` is low, set `pending[issue_waddr_i]` on the edge.
  - While `hazard_o` is high, the set is suppressed internally.
- **Same address set and clear in one cycle:** set wins; the new producer is outstanding.
- **Hazard:** `hazard_o` = OR over N of (`reN` and `raddrN` != 0 and `pending[raddrN]` and not `bypass_hitN`).
- **Pending count:** `pending_cnt_o` is a registered population count of `pending`.
  - Incremented or decremented in the same edge as each bit change.
  - A net-zero change (set and clear on different addresses) holds the count.
  - Saturates at REG_NUM-1.

## Timing
- Read latency is 0 cycles, combinational from address, enable and storage.
- A write is visible to a non-bypassed read on the cycle after the write edge.
- `hazard_o` is combinational. It drops in the cycle after the clearing write-back edge, or in the same cycle when bypass is enabled.
- Reset is asynchronous and active-high. Asserting `rst` mid-operation immediately zeroes storage, pending bits and count; reads return 0 and `hazard_o` goes low.
- Reset release takes effect on the next edge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** when `reg_we_i` is high, `reg_waddr_i` != 0 and `reg_waddr_i` == `raddrN`, then `bypass_hitN` = 1 and `regN_rdata_o` = `reg_wdata_i` in the same cycle. That read also produces no hazard.
- **Undefined:** `bypass_hitN` = 0; reads return stored values and a dependent read stalls one extra cycle.

## Structure
- **Shared package/defines:** `RADDR_WIDTH`, `RDATA_WIDTH`, `REG_NUM`, `ZERO_REG` (5'd0), `ZERO` (32'd0), `READ_ENABLE`/`READ_DISABLE`, `WRITE_ENABLE`/`WRITE_DISABLE`.
- **Sub-module:** `regfile_scoreboard`, holding the pending bit vector, set/clear priority, population counter and hazard compare.
- **Top:** owns the storage array and the read/bypass muxes.

## Test plan
- **Reset:** hold `rst`=1 and read x5 on both ports -> `reg1_rdata_o` = `reg2_rdata_o` = 0, `hazard_o` = 0, `pending_cnt_o` = 0.
- **x0:** write x0 = 0xDEADBEEF, then read x0 -> 0, and `pending_cnt_o` is unchanged.
- **Basic write/read:** write x3 = 0x12345678, next cycle read x3 on port 2 -> 0x12345678. Repeat with `reg2_re_i` = 0 -> 0.
- **RAW stall:**
  - Issue a write to x7 -> `pending_cnt_o` = 1.
  - Read x7 -> `hazard_o` = 1.
  - Write-back x7 = 0xA5 -> with bypass, same cycle `hazard_o` = 0 and data = 0xA5; without bypass, the cycle after.
- **Set/clear collision:** x9 pending; write-back x9 and issue x9 in the same cycle -> x9 stays pending, count unchanged.
- **Async reset mid-operation:** x4 and x6 pending, `rst` pulsed between edges -> `hazard_o`, count and data go to 0 immediately.
